keypad_ctrl: RTL

Matrix-keypad controller for the 4x4 keypad. It drives the active-low row strobes at a paced rate and samples the column returns through a synchronizer. It debounces press and release, locks the scan while a key is held, and delivers one key event per press over a valid/ready handshake to the consuming logic (display or command decoder). It supersedes free-running scan-and-latch: the rest of the design sees clean, single-shot key events instead of a level that silently changes.

---
 rtl/keypad_pkg.sv | 53 +++++
 rtl/keypad_sync.sv | 35 +++
 rtl/keypad_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and constants for the 4x4 matrix-keypad controller.
//   state_t     : controller FSM states (SCAN, DEBOUNCE, PRESSED, RELEASE)
//   ROW0..ROW3  : active-low row strobe codes, one bit low at a time
//   NO_KEY      : column return value with no key pressed
//   is_one_low  : true when exactly one bit of a 4-bit word is low
//   low_index   : index of the single low bit of a one-hot-low word
//   next_row    : row strobe rotation, illegal codes fall back to ROW0
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] ROW0   = 4'b1110;
    localparam logic [3:0] ROW1   = 4'b1101;
    localparam logic [3:0] ROW2   = 4'b1011;
    localparam logic [3:0] ROW3   = 4'b0111;
    localparam logic [3:0] NO_KEY = 4'b1111;

    function automatic logic is_one_low(input logic [3:0] v);
        return (v == ROW0) || (v == ROW1) || (v == ROW2) || (v == ROW3);
    endfunction

    // Only meaningful for one-hot-low input; anything else maps to 0.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            ROW1:    idx = 2'd1;
            ROW2:    idx = 2'd2;
            ROW3:    idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] next_row(input logic [3:0] v);
        logic [3:0] nxt;
        case (v)
            ROW0:    nxt = ROW1;
            ROW1:    nxt = ROW2;
            ROW2:    nxt = ROW3;
            default: nxt = ROW0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// -----------------------------------------------------------------------------
// keypad_sync
// Two-flop synchronizer for the asynchronous column returns. Both stages
// reset to NO_KEY so a reset never looks like a key press.
// Ports:
//   i_clk  in  system clock, rising edge
//   i_rst  in  asynchronous active-high reset
//   i_d    in  [3:0] raw column returns (asynchronous)
//   o_q    out [3:0] synchronized column returns
// -----------------------------------------------------------------------------
module keypad_sync
    import keypad_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_d,
    output logic [3:0] o_q
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= NO_KEY;
            r_sync <= NO_KEY;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_ctrl
// 4x4 matrix-keypad scanner. Strobes rows low one at a time, samples the
// synchronized column returns once per scan tick, debounces press and
// release, holds the row while a key is down and hands one key event per
// press to the consumer.
//
// Optional feature: define KEYPAD_REPEAT_EN to get auto-repeat events while
// a key stays pressed (first after REPEAT_DLY ticks, then every REPEAT_RATE
// ticks). Without it each press yields exactly one event.
//
// Parameters:
//   SCAN_DIV    clocks per scan tick / row dwell (>= 4)
//   DB_CNT      stable ticks needed to accept a press or a release (>= 1)
//   REPEAT_DLY  ticks from press event to first repeat
//   REPEAT_RATE ticks between later repeats
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   SWC        in   [3:0] column returns, active-low, asynchronous
//   SWR        out  [3:0] row strobes, one bit low
//   key_code   out  [3:0] row_index*4 + col_index of the last event
//   key_valid  out  event pending
//   key_ready  in   consumer accept
//   key_held   out  high while a key is debounced-pressed
//   key_drop   out  one-cycle pulse when an event was discarded
//   dbg_state  out  current FSM state
//
// Handshake: an event transfers on a clock edge where key_valid && key_ready.
// key_valid stays high with key_code stable until that transfer. A new event
// arriving while an earlier one is still pending is discarded (key_drop),
// unless the pending one transfers on that same edge, in which case the new
// event takes its place.
// -----------------------------------------------------------------------------
module keypad_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV    = 16,
    parameter int DB_CNT      = 4,
    parameter int REPEAT_DLY  = 64,
    parameter int REPEAT_RATE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] SWC,
    output logic [3:0] SWR,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       key_drop,
    output state_t     dbg_state
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = (DB_CNT < 2) ? 1 : $clog2(DB_CNT);

    // Elaboration-time parameter sanity checks.
    if (SCAN_DIV < 4) begin : g_bad_scan_div
        $error("keypad_ctrl: SCAN_DIV must be at least 4");
    end
    if (DB_CNT < 1) begin : g_bad_db_cnt
        $error("keypad_ctrl: DB_CNT must be at least 1");
    end
    if (REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
        $error("keypad_ctrl: REPEAT_DLY and REPEAT_RATE must be at least 1");
    end

    logic [3:0]    w_swc_s;
    logic [PW-1:0] r_presc;
    logic          w_tick;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_swr;
    logic [3:0]    r_pat;
    logic [3:0]    r_cap_code;
    logic [3:0]    r_code;
    logic [DW-1:0] r_db_cnt;
    logic          r_valid;
    logic          r_held;
    logic          r_drop;

    logic w_one_low;
    logic w_match;
    logic w_idle;
    logic w_db_done;
    logic w_swr_legal;
    logic w_capture;
    logic w_rotate;
    logic w_db_inc;
    logic w_db_clr;
    logic w_press_ev;
    logic w_rep_ev;
    logic w_emit;

    keypad_sync u_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (SWC),
        .o_q   (w_swc_s)
    );

    // ---------------- scan prescaler ----------------
    assign w_tick = (r_presc == PW'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // ---------------- column classification ----------------
    assign w_one_low   = is_one_low(w_swc_s);
    assign w_match     = (w_swc_s == r_pat);
    assign w_idle      = (w_swc_s == NO_KEY);
    // db_cnt holds the number of stable ticks already seen; this tick is the
    // DB_CNT-th one when the count is one short.
    assign w_db_done   = (r_db_cnt == DW'(DB_CNT - 1));
    assign w_swr_legal = is_one_low(r_swr);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (w_one_low) w_state_nxt = DEBOUNCE;
                end
                DEBOUNCE: begin
                    if (!w_match)       w_state_nxt = SCAN;
                    else if (w_db_done) w_state_nxt = PRESSED;
                end
                PRESSED: begin
                    if (!w_match) w_state_nxt = RELEASE;
                end
                RELEASE: begin
                    if (w_idle) begin
                        if (w_db_done) w_state_nxt = SCAN;
                    end else if (w_match) begin
                        w_state_nxt = PRESSED;
                    end
                end
                default: w_state_nxt = SCAN;
            endcase
        end
    end

    // ---------------- FSM: action strobes ----------------
    always_comb begin
        w_capture  = 1'b0;
        w_rotate   = 1'b0;
        w_db_inc   = 1'b0;
        w_db_clr   = 1'b0;
        w_press_ev = 1'b0;
        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (w_one_low) begin
                        w_capture = 1'b1;
                        w_db_clr  = 1'b1;
                    end else begin
                        w_rotate = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (w_match) begin
                        w_db_inc   = 1'b1;
                        w_press_ev = w_db_done;
                    end else begin
                        w_rotate = 1'b1;
                    end
                end
                PRESSED: begin
                    if (!w_match) w_db_clr = 1'b1;
                end
                RELEASE: begin
                    if (w_idle) begin
                        w_db_inc = 1'b1;
                        w_rotate = w_db_done;
                    end else if (!w_match) begin
                        // Neither released nor the original key: restart the
                        // release count.
                        w_db_clr = 1'b1;
                    end
                end
                default: w_rotate = 1'b1;
            endcase
        end
    end

    // ---------------- auto-repeat ----------------
`ifdef KEYPAD_REPEAT_EN
    localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int RW   = (RMAX < 2) ? 1 : $clog2(RMAX);

    logic [RW-1:0] r_rep_cnt;
    logic          r_rep_phase;   // 0: waiting for first repeat, 1: steady rate
    logic          w_rep_run;

    assign w_rep_run = w_tick && (r_state == PRESSED) && w_match;
    assign w_rep_ev  = w_rep_run &&
                       (r_rep_cnt == (r_rep_phase ? RW'(REPEAT_RATE - 1)
                                                  : RW'(REPEAT_DLY - 1)));

    // Cleared whenever we are not staying in PRESSED, so a RELEASE->PRESSED
    // bounce restarts the delay from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
        end else if (r_state != PRESSED || (w_tick && !w_match)) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
        end else if (w_rep_run) begin
            if (w_rep_ev) begin
                r_rep_cnt   <= '0;
                r_rep_phase <= 1'b1;
            end else begin
                r_rep_cnt <= r_rep_cnt + RW'(1);
            end
        end
    end
`else
    assign w_rep_ev = 1'b0;
`endif

    assign w_emit = w_press_ev || w_rep_ev;

    // ---------------- row strobe, capture, debounce counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_swr <= ROW0;
        end else if (!w_swr_legal) begin
            r_swr <= ROW0;
        end else if (w_rotate) begin
            r_swr <= next_row(r_swr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat      <= NO_KEY;
            r_cap_code <= 4'd0;
        end else if (w_capture) begin
            r_pat      <= w_swc_s;
            r_cap_code <= {low_index(r_swr), low_index(w_swc_s)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_cnt <= '0;
        end else if (w_db_clr) begin
            r_db_cnt <= '0;
        end else if (w_db_inc) begin
            r_db_cnt <= w_db_done ? '0 : r_db_cnt + DW'(1);
        end
    end

    // ---------------- event slot ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code  <= 4'd0;
            r_valid <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            if (w_emit) begin
                if (!r_valid || key_ready) begin
                    r_code  <= r_cap_code;
                    r_valid <= 1'b1;
                end else begin
                    r_drop <= 1'b1;
                end
            end else if (r_valid && key_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Registered from next state so it rises on the same edge as key_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_held <= 1'b0;
        end else begin
            r_held <= (w_state_nxt == PRESSED) || (w_state_nxt == RELEASE);
        end
    end

    assign SWR       = r_swr;
    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign key_held  = r_held;
    assign key_drop  = r_drop;
    assign dbg_state = r_state;

endmodule
